fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  IF stage and IF/ID pipeline register of the RV32 pipeline. Holds PCF and issues in-order instruction-memory reads.
//  Pairs each returned word with its PC in a small in-order buffer and presents InstrD/PCD/PCPlus4D/ValidD to the decoder.
//  Applies hazard-unit stall/flush and EX-stage redirects (branch, jal, jalr), discarding stale in-flight responses.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PCF value after reset
//  BUF_DEPTH  2              instruction buffer entries; power of 2, >=2; also max outstanding reads
// PORTS
//  clk         in   1   clock, all state on rising edge
//  rst_n       in   1   asynchronous active-low reset
//  StallF      in   1   hazard unit: hold PCF, issue no new request
//  StallD      in   1   hazard unit: hold IF/ID register
//  FlushD      in   1   hazard unit: turn IF/ID into bubble
//  PCSrcE      in   1   redirect from EX, one-cycle pulse
//  PCTargetE   in   32  redirect target; bits[1:0] are 0
//  IMemValid   out  1   read request valid
//  IMemAddr    out  32  read address (= PCF)
//  IMemReady   in   1   memory accepts request when IMemValid&IMemReady
//  IMemRValid  in   1   read data valid; responses return in request order, >=1 cycle after acceptance
//  IMemRData   in   32  read data
//  InstrD      out  32  instruction to decoder
//  PCD         out  32  PC of InstrD
//  PCPlus4D    out  32  PCD+4
//  ValidD      out  1   InstrD is a real instruction
// BEHAVIOUR
//  Reset: PCF=RESET_PC. IMemValid=0. Buffer empty. kill=0. InstrD=32'h0000_0013 (NOP). PCD=0. PCPlus4D=0. ValidD=0.
//  Buffer entry holds {pc, instr, filled}. Pointers: alloc (at issue), fill (at response), rd (at IF/ID load); all wrap mod BUF_DEPTH.
//  Issue rule:
//   - IMemValid = ~StallF & ~PCSrcE & (occupancy + kill < BUF_DEPTH).
//   - IMemValid is combinational; IMemAddr=PCF.
//   - Handshake: allocate entry {PCF, -, filled=0}, PCF<=PCF+4 (32-bit wrap).
//  Response:
//   - If kill>0: kill-=1 and data dropped.
//   - Else: write instr at fill ptr, set filled.
//   - Response with no outstanding request is illegal; assertion only.
//  IF/ID load, when ~StallD & ~FlushD & ~PCSrcE:
//   - Head filled: load InstrD/PCD/PCPlus4D, ValidD=1, pop.
//   - Otherwise: InstrD=NOP, ValidD=0; PCD/PCPlus4D hold.
//   - Same-cycle fill of the head entry is NOT bypassed; it becomes visible the next cycle.
//   - Min latency: request accepted at t, response at t+1, ValidD=1 at t+2.
//  StallD=1 and no flush: IF/ID holds; the buffer keeps filling until full.
//  FlushD=1 (StallD ignored): InstrD=NOP, ValidD=0 next cycle; buffer untouched.
//  Redirect (PCSrcE=1), highest priority:
//   - PCF<=PCTargetE.
//   - All buffer entries discarded; pointers reset to 0.
//   - kill<=kill+unfilled-(IMemRValid?1:0).
//   - IF/ID bubble next cycle; no issue this cycle. Overrides StallF.
//  Counters (occupancy 0..BUF_DEPTH, kill 0..BUF_DEPTH) never exceed BUF_DEPTH; assertion checked.
//  Reset mid-operation: state returns to reset values immediately. Responses still in flight are the memory's concern; the memory is reset together.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined:
//   - Adds outputs PerfFetchCnt[31:0] (+1 per ValidD load) and PerfBubbleCnt[31:0] (+1 per cycle IF/ID loads a bubble while not stalled).
//   - Both reset to 0 and wrap.
//  Undefined: ports and logic absent; no other behavioural difference.
// STRUCTURE
//  rv_pkg: NOP_INSTR=32'h0000_0013, RESET_PC_DEF, typedef struct packed {logic [31:0] pc, instr; logic filled;} fetch_entry_t.
//  Sub-module fetch_buf: entry array, pointers, occupancy, alloc/fill/pop/clear ports.
//  fetch_stage keeps PCF, kill counter, issue logic and the IF/ID register.
// TESTING
//  T1 reset: rst_n low mid-run -> ValidD=0, InstrD=0x00000013, IMemAddr=RESET_PC next edge.
//  T2 streaming: always-ready 1-cycle memory returning addr^0xA5A5_0000 -> ValidD=1 from cycle 3; PCD=0,4,8,... back-to-back, no bubbles.
//  T3 backpressure: IMemReady low 3 cycles -> PCF holds; exactly 3 bubbles; no duplicated or skipped PC.
//  T4 stall: StallD=1 for 4 cycles -> InstrD/PCD frozen; IMemValid drops once occupancy=2; release resumes in order.
//  T5 redirect with 2 reads in flight: PCSrcE, PCTargetE=0x100 -> both late responses dropped; next ValidD has PCD=0x100.
//  T6 PCSrcE coincident with IMemRValid and FlushD -> the coincident response is dropped, kill=1; ValidD=0 next cycle; order kept from 0x100.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared fetch-path types and constants for the RV32 pipeline.
// Used by fetch_buf and fetch_stage.
package rv_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// In-order instruction buffer: entries are allocated at request issue, filled at
// response and popped into IF/ID; a clear drops every entry.
module fetch_buf
  import rv_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         alloc_i,
  input  logic [31:0]  alloc_pc_i,
  input  logic         fill_i,
  input  logic [31:0]  fill_instr_i,
  input  logic         pop_i,
  input  logic         clear_i,
  output fetch_entry_t head_o,
  output logic         head_filled_o,
  output logic [CW-1:0] occ_o,
  output logic [CW-1:0] unfilled_o
);

  localparam int unsigned AW = CW - 1;

  // Pointers carry one extra wrap bit so occupancy is a plain difference.
  logic [CW-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [CW-1:0] fill_ptr_q,  fill_ptr_d;
  logic [CW-1:0] rd_ptr_q,    rd_ptr_d;
  fetch_entry_t  entries_q [DEPTH];
  fetch_entry_t  entries_d [DEPTH];

  always_comb begin
    entries_d   = entries_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (clear_i) begin
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      rd_ptr_d    = '0;
    end else begin
      if (alloc_i) begin
        entries_d[alloc_ptr_q[AW-1:0]] = '{pc: alloc_pc_i, instr: '0, filled: 1'b0};
        alloc_ptr_d = alloc_ptr_q + CW'(1);
      end
      if (fill_i) begin
        entries_d[fill_ptr_q[AW-1:0]].instr  = fill_instr_i;
        entries_d[fill_ptr_q[AW-1:0]].filled = 1'b1;
        fill_ptr_d = fill_ptr_q + CW'(1);
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      rd_ptr_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      entries_q   <= entries_d;
    end
  end

  always_comb begin
    head_o        = entries_q[rd_ptr_q[AW-1:0]];
    occ_o         = alloc_ptr_q - rd_ptr_q;
    unfilled_o    = alloc_ptr_q - fill_ptr_q;
    head_filled_o = (occ_o != '0) && head_o.filled;
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32 IF stage plus IF/ID register: PCF, in-order imem requests, stale-response kill.
// Optional perf counters when FETCH_PERF_CNT_EN is defined.
module fetch_stage
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        IMemValid,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic        IMemRValid,
  input  logic [31:0] IMemRData,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] PerfFetchCnt,
  output logic [31:0] PerfBubbleCnt,
`endif
  output logic        ValidD
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

  logic [31:0]   pcf_q, pcf_d;
  logic [CW-1:0] kill_q, kill_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   pcd_q, pcd_d;
  logic [31:0]   pcp4_q, pcp4_d;
  logic          valid_q, valid_d;

  fetch_entry_t  head;
  logic          head_filled;
  logic [CW-1:0] occ;
  logic [CW-1:0] unfilled;
  logic [CW:0]   inflight;
  logic          fire;
  logic          fill;
  logic          pop;
  logic          bubble_load;

  fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_i      (fire),
    .alloc_pc_i   (pcf_q),
    .fill_i       (fill),
    .fill_instr_i (IMemRData),
    .pop_i        (pop),
    .clear_i      (PCSrcE),
    .head_o       (head),
    .head_filled_o(head_filled),
    .occ_o        (occ),
    .unfilled_o   (unfilled)
  );

  always_comb begin
    inflight    = {1'b0, occ} + {1'b0, kill_q};
    IMemValid   = rst_n & ~StallF & ~PCSrcE & (inflight < (CW+1)'(BUF_DEPTH));
    IMemAddr    = pcf_q;
    fire        = IMemValid & IMemReady;
    fill        = IMemRValid & (kill_q == '0) & ~PCSrcE;
    pop         = ~PCSrcE & ~FlushD & ~StallD & head_filled;
    bubble_load = (PCSrcE | FlushD | ~StallD) & ~pop;
  end

  // A redirect turns every still-unfilled request into a kill credit; a response
  // arriving in that same cycle is retired from the credit straight away.
  always_comb begin
    kill_d = kill_q;
    pcf_d  = pcf_q;
    if (PCSrcE) begin
      kill_d = kill_q + unfilled - CW'(IMemRValid);
      pcf_d  = PCTargetE;
    end else begin
      if (IMemRValid && (kill_q != '0)) kill_d = kill_q - CW'(1);
      if (fire)                         pcf_d  = pcf_q + 32'd4;
    end
  end

  always_comb begin
    instr_d = instr_q;
    pcd_d   = pcd_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    if (pop) begin
      instr_d = head.instr;
      pcd_d   = head.pc;
      pcp4_d  = head.pc + 32'd4;
      valid_d = 1'b1;
    end else if (bubble_load) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcf_q   <= RESET_PC;
      kill_q  <= '0;
      instr_q <= NOP_INSTR;
      pcd_q   <= '0;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pcf_q   <= pcf_d;
      kill_q  <= kill_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  assign InstrD   = instr_q;
  assign PCD      = pcd_q;
  assign PCPlus4D = pcp4_q;
  assign ValidD   = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q + {31'd0, pop};
    bubble_cnt_d = bubble_cnt_q + {31'd0, bubble_load & ~StallD};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign PerfFetchCnt  = fetch_cnt_q;
  assign PerfBubbleCnt = bubble_cnt_q;
`endif

  a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
    IMemRValid |-> ((kill_q != '0) || (unfilled != '0)));
  a_counters_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    (occ <= CW'(BUF_DEPTH)) && (kill_q <= CW'(BUF_DEPTH)));

endmodule
